// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, registers fetched words into IF/ID, handles stall/redirect/halt.
// Optional performance counters are built when IFU_PERF_COUNT_EN is defined.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter logic [63:0] IMEM_BYTES = 64'd256,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    input  logic [31:0] instruction,
    output logic [63:0] pc,
    output logic [31:0] if_id_instr,
    output logic [63:0] if_id_pc,
    output logic        if_id_valid,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [63:0] if_id_pc_q, if_id_pc_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        halted_q, halted_d;
    logic [1:0]  halt_cause_q, halt_cause_d;

    // Edge resolution in RUN; HALT holds everything until reset.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_valid_d = if_id_valid_q;
        halted_d      = halted_q;
        halt_cause_d  = halt_cause_q;
        if (state_q == RUN) begin
            if (branch_taken && (branch_target[1:0] != 2'b00)) begin
                state_d       = HALT;
                halted_d      = 1'b1;
                halt_cause_d  = 2'b10;
                if_id_instr_d = NOP_INSTR;
                if_id_valid_d = 1'b0;
            end else if (branch_taken) begin
                pc_d          = branch_target;
                if_id_instr_d = NOP_INSTR;
                if_id_valid_d = 1'b0;
            end else if (pc_q >= IMEM_BYTES) begin
                state_d       = HALT;
                halted_d      = 1'b1;
                halt_cause_d  = 2'b01;
                if_id_instr_d = NOP_INSTR;
                if_id_valid_d = 1'b0;
            end else if (!stall) begin
                if_id_instr_d = instruction;
                if_id_pc_d    = pc_q;
                if_id_valid_d = 1'b1;
                pc_d          = pc_q + 64'd4;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc_q    <= 64'd0;
            if_id_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            halt_cause_q  <= 2'b00;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_valid_q <= if_id_valid_d;
            halted_q      <= halted_d;
            halt_cause_q  <= halt_cause_d;
        end
    end

    assign pc          = pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_valid = if_id_valid_q;
    assign halted      = halted_q;
    assign halt_cause  = halt_cause_q;

`ifdef IFU_PERF_COUNT_EN
    logic        fetch_fire, stall_fire;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    // Only priority-4/5 resolutions count, so branch and out-of-range edges are excluded.
    assign fetch_fire = (state_q == RUN) && !branch_taken && (pc_q < IMEM_BYTES) && !stall;
    assign stall_fire = (state_q == RUN) && !branch_taken && (pc_q < IMEM_BYTES) && stall;

    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (fetch_fire && (fetch_count_q != 32'hFFFFFFFF)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (stall_fire && (stall_count_q != 32'hFFFFFFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q <= 32'd0;
            stall_count_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`else
    assign fetch_count = 32'd0;
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed test-plan steps plus randomized
// stall/branch traffic compared against a behavioural model of the fetch rules.
module tb_instruction_fetch_unit;

    localparam logic [63:0] RESET_PC = 64'h0;
    localparam logic [31:0] NOP      = 32'h00000013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, stall, branch_taken;
    logic [63:0] branch_target;
    logic [31:0] instruction, small_instruction;
    logic [63:0] pc, if_id_pc, small_pc, small_if_id_pc;
    logic [31:0] if_id_instr, fetch_count, stall_count;
    logic [31:0] small_if_id_instr, small_fetch_count, small_stall_count;
    logic        if_id_valid, halted, small_if_id_valid, small_halted;
    logic [1:0]  halt_cause, small_halt_cause;

    logic [31:0] mem [64];

    assign instruction       = (pc < 64'd256) ? mem[pc[7:2]] : 32'hDEADBEEF;
    assign small_instruction = (small_pc < 64'd256) ? mem[small_pc[7:2]] : 32'hDEADBEEF;

    instruction_fetch_unit #(.RESET_PC(RESET_PC), .IMEM_BYTES(64'd256), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .instruction(instruction), .pc(pc),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
        .halted(halted), .halt_cause(halt_cause), .fetch_count(fetch_count),
        .stall_count(stall_count)
    );

    // Small-memory instance used for the out-of-range halt scenario.
    instruction_fetch_unit #(.RESET_PC(64'h0), .IMEM_BYTES(64'd12), .NOP_INSTR(NOP)) dut_small (
        .clk(clk), .reset(reset), .stall(1'b0), .branch_taken(1'b0),
        .branch_target(64'd0), .instruction(small_instruction), .pc(small_pc),
        .if_id_instr(small_if_id_instr), .if_id_pc(small_if_id_pc),
        .if_id_valid(small_if_id_valid), .halted(small_halted),
        .halt_cause(small_halt_cause), .fetch_count(small_fetch_count),
        .stall_count(small_stall_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_instr;
    logic        m_valid, m_halted;
    logic [1:0]  m_cause;
    int unsigned m_fc, m_sc;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a < 64'd256) return mem[a[7:2]];
        return 32'hDEADBEEF;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_ipc = 64'd0; m_instr = NOP; m_valid = 1'b0;
        m_halted = 1'b0; m_cause = 2'd0; m_fc = 0; m_sc = 0;
    endtask

    task automatic model_edge(input logic st, input logic bt, input logic [63:0] tgt);
        if (m_halted) return;
        if (bt && (tgt % 4 != 0)) begin
            m_halted = 1'b1; m_cause = 2'd2; m_instr = NOP; m_valid = 1'b0;
        end else if (bt) begin
            m_pc = tgt; m_instr = NOP; m_valid = 1'b0;
        end else if (m_pc >= 64'd256) begin
            m_halted = 1'b1; m_cause = 2'd1; m_instr = NOP; m_valid = 1'b0;
        end else if (st) begin
            m_sc++;
        end else begin
            m_instr = mem_word(m_pc); m_ipc = m_pc; m_valid = 1'b1;
            m_pc = m_pc + 64'd4; m_fc++;
        end
    endtask

    task automatic check_main(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".if_id_instr"}, 64'(if_id_instr), 64'(m_instr));
        chk({tag, ".if_id_pc"}, if_id_pc, m_ipc);
        chk({tag, ".if_id_valid"}, 64'(if_id_valid), 64'(m_valid));
        chk({tag, ".halted"}, 64'(halted), 64'(m_halted));
        chk({tag, ".halt_cause"}, 64'(halt_cause), 64'(m_cause));
`ifdef IFU_PERF_COUNT_EN
        chk({tag, ".fetch_count"}, 64'(fetch_count), 64'(m_fc));
        chk({tag, ".stall_count"}, 64'(stall_count), 64'(m_sc));
`else
        chk({tag, ".fetch_count"}, 64'(fetch_count), 64'd0);
        chk({tag, ".stall_count"}, 64'(stall_count), 64'd0);
`endif
    endtask

    // Bench sits at a falling edge between steps.
    task automatic applyStimulus(input logic st, input logic bt, input logic [63:0] tgt, input string tag);
        stall = st; branch_taken = bt; branch_target = tgt;
        @(posedge clk);
        model_edge(st, bt, tgt);
        #1;
        check_main(tag);
        @(negedge clk);
    endtask

    task automatic applyReset(input string tag);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_main(tag);
        chk({tag, ".small_pc"}, small_pc, 64'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [63:0] tgt;
        int halted_steps;
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'd0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h00003083; mem[1] = 32'h00503103; mem[2] = 32'h021101B3;
        model_reset();
        @(negedge clk);

        // Sequential fetch, with the small instance running alongside.
        applyReset("reset0");
        applyStimulus(1'b0, 1'b0, 64'd0, "seq1");
        chk("seq1.instr", 64'(if_id_instr), 64'h00003083);
        applyStimulus(1'b0, 1'b0, 64'd0, "seq2");
        chk("seq2.instr", 64'(if_id_instr), 64'h00503103);
        chk("seq2.pc_of", if_id_pc, 64'd4);
        applyStimulus(1'b0, 1'b0, 64'd0, "seq3");
        chk("seq3.instr", 64'(if_id_instr), 64'h021101B3);
        chk("seq3.pc", pc, 64'd12);
        chk("small3.if_id_pc", small_if_id_pc, 64'd8);
        chk("small3.valid", 64'(small_if_id_valid), 64'd1);
        applyStimulus(1'b0, 1'b0, 64'd0, "seq4");
        chk("small4.halted", 64'(small_halted), 64'd1);
        chk("small4.cause", 64'(small_halt_cause), 64'd1);
        chk("small4.valid", 64'(small_if_id_valid), 64'd0);
        chk("small4.instr", 64'(small_if_id_instr), 64'(NOP));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 64'd0, "seq_more");
            chk("small_hold.pc", small_pc, 64'd12);
            chk("small_hold.halted", 64'(small_halted), 64'd1);
        end

        // Stall after the first fetch, then branch flush overriding stall.
        applyReset("reset1");
        applyStimulus(1'b0, 1'b0, 64'd0, "stall_pre");
        applyStimulus(1'b1, 1'b0, 64'd0, "stall1");
        applyStimulus(1'b1, 1'b0, 64'd0, "stall2");
        chk("stall.pc", pc, 64'd4);
        chk("stall.if_id_pc", if_id_pc, 64'd0);
        chk("stall.instr", 64'(if_id_instr), 64'h00003083);
`ifdef IFU_PERF_COUNT_EN
        chk("stall.count", 64'(stall_count), 64'd2);
`else
        chk("stall.count", 64'(stall_count), 64'd0);
`endif
        applyStimulus(1'b0, 1'b0, 64'd0, "to_pc8");
        chk("to_pc8.pc", pc, 64'd8);
        applyStimulus(1'b1, 1'b1, 64'd0, "flush");
        chk("flush.valid", 64'(if_id_valid), 64'd0);
        chk("flush.instr", 64'(if_id_instr), 64'(NOP));
        chk("flush.pc", pc, 64'd0);
        applyStimulus(1'b0, 1'b0, 64'd0, "after_flush");
        chk("after_flush.if_id_pc", if_id_pc, 64'd0);
        chk("after_flush.instr", 64'(if_id_instr), 64'h00003083);

        // Randomized stall/branch traffic; reset a few edges after every halt.
        halted_steps = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(19) == 0)
                tgt = {54'($urandom_range(255)), 8'h0, 2'($urandom_range(1, 3))};
            else
                tgt = 64'($urandom_range(70)) * 64'd4;
            applyStimulus($urandom_range(99) < 30, $urandom_range(99) < 10, tgt, "rand");
            if (m_halted) begin
                halted_steps++;
                if (halted_steps >= 3) begin
                    applyReset("rand_reset");
                    halted_steps = 0;
                end
            end
        end

        // Misaligned target halts without moving pc; inputs ignored afterwards.
        applyReset("reset2");
        applyStimulus(1'b0, 1'b0, 64'd0, "mis_pre");
        applyStimulus(1'b0, 1'b1, 64'h6, "misaligned");
        chk("mis.halted", 64'(halted), 64'd1);
        chk("mis.cause", 64'(halt_cause), 64'd2);
        chk("mis.pc", pc, 64'd4);
        applyStimulus(1'b0, 1'b1, 64'h40, "halt_hold");
        chk("halt_hold.pc", pc, 64'd4);

        // Asynchronous reset out of HALT, then first fetch at RESET_PC.
        applyReset("reset_from_halt");
        chk("rfh.halted", 64'(halted), 64'd0);
        applyStimulus(1'b0, 1'b0, 64'd0, "rfh_fetch");
        chk("rfh.if_id_pc", if_id_pc, RESET_PC);
        chk("rfh.instr", 64'(if_id_instr), 64'h00003083);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch stage of the 64-bit RISC-V single-cycle/pipelined CPU. It owns the program counter and drives it into `instruction_memory`, which returns the addressed word combinationally in the same cycle. The unit registers each fetched word and its PC into an IF/ID output register for decode. It also handles stall, branch redirect with flush, and halt on fault.

## Interface
Parameters:
- `RESET_PC`, default 64'h0: PC value loaded on reset.
- `IMEM_BYTES`, default 256: instruction memory size in bytes. Any PC ≥ this value is out of range.
- `NOP_INSTR`, default 32'h00000013: bubble word (`addi x0,x0,0`).

Ports:
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `stall`  in  1: hold the PC and IF/ID register.
- `branch_taken`  in  1: redirect fetch to `branch_target`.
- `branch_target`  in  64: redirect byte address.
- `instruction`  in  32: word returned by `instruction_memory` for the current `pc`.
- `pc`  out  64: fetch address to `instruction_memory`.
- `if_id_instr`  out  32: registered instruction.
- `if_id_pc`  out  64: PC of `if_id_instr`.
- `if_id_valid`  out  1: `if_id_instr` is a real fetched instruction.
- `halted`  out  1: unit is in HALT.
- `halt_cause`  out  2: 00 none, 01 PC out of range, 10 misaligned branch target.
- `fetch_count`  out  32: performance counter (see Configuration).
- `stall_count`  out  32: performance counter (see Configuration).

## Operation
State machine with two states, RUN and HALT. Reset enters RUN. HALT is left only by reset.

Reset values:
- `pc` = `RESET_PC`
- `if_id_instr` = `NOP_INSTR`
- `if_id_pc` = 0
- `if_id_valid` = 0
- `halted` = 0
- `halt_cause` = 00
- both counters = 0

In RUN, each rising edge is resolved in this priority order:
1. **Misaligned redirect.** `branch_taken` is 1 and `branch_target[1:0]` ≠ 0. Go to HALT, `halt_cause` = 10, `pc` unchanged, IF/ID gets a bubble.
2. **Branch.** `branch_taken` is 1. `pc` ← `branch_target`. IF/ID gets a bubble (`if_id_instr` = `NOP_INSTR`, `if_id_valid` = 0, `if_id_pc` unchanged). Branch overrides `stall`.
3. **Out of range.** `pc` ≥ `IMEM_BYTES`. Go to HALT, `halt_cause` = 01, IF/ID gets a bubble. `instruction` is ignored.
4. **Stall.** `stall` is 1. `pc` and all IF/ID outputs hold.
5. **Normal fetch.** `if_id_instr` ← `instruction`, `if_id_pc` ← `pc`, `if_id_valid` ← 1, `pc` ← `pc` + 4.

Other rules:
- In HALT, every output holds, `halted` = 1, and all inputs are ignored.
- PC arithmetic is 64-bit modulo 2^64. `pc` + 4 wrapping at 2^64−4 is not special-cased; the wrapped value reaching 0 is simply fetched (it is in range when `IMEM_BYTES` > 0).
- A `RESET_PC` that is out of range halts on the first edge after reset.
- `halted` and `halt_cause` are registered and update on the same edge as the HALT transition.

## Timing
- Memory read is combinational. The word for `pc` appears on `if_id_instr` one edge later (fetch latency 1 cycle).
- A branch costs one bubble. The target word is valid on IF/ID on the second edge after `branch_taken` is sampled.
- `stall` is sampled at the edge only. No combinational path runs from any input to `pc`.
- Reset mid-operation takes effect immediately and asynchronously, including from HALT. Counters also clear.
- When reset is released, the first edge performs a normal fetch at `RESET_PC`.

## Configuration
- `IFU_PERF_COUNT_EN` defined:
  - `fetch_count` increments on every normal fetch (priority 5).
  - `stall_count` increments on every RUN edge resolved as a stall (priority 4).
  - Both counters saturate at 32'hFFFFFFFF and hold in HALT.
- Not defined: both counter outputs are tied to 0 and no counter flops are built.

## Test plan
- **Sequential fetch.** Memory model holds words 0x00003083, 0x00503103, 0x021101B3 at 0/4/8. Release reset and clock 3 edges. Required: IF/ID shows (0, 0x00003083), then (4, 0x00503103), then (8, 0x021101B3), all valid; `pc` = 12.
- **Stall.** Assert `stall` for 2 edges after the first fetch. Required: `pc` = 4 and IF/ID = (0, 0x00003083) held; `stall_count` = 2 with the macro, 0 without.
- **Branch flush.** At `pc` = 8, assert `branch_taken` with `branch_target` = 0, together with `stall`. Required: `if_id_valid` = 0, `if_id_instr` = 0x00000013, `pc` = 0. Next edge: IF/ID = (0, 0x00003083).
- **Out-of-range halt.** Set `IMEM_BYTES` = 12 and run from 0. Required: after the edge at `pc` = 12, `halted` = 1, `halt_cause` = 01, `if_id_valid` = 0, `pc` stays 12 for 5 further edges.
- **Misaligned target.** Assert `branch_taken` with `branch_target` = 0x6. Required: `halted` = 1, `halt_cause` = 10, `pc` unchanged.
- **Reset from HALT.** Assert `reset` mid-cycle while in HALT. Required: outputs return immediately to their reset values. After release, the first edge fetches (`RESET_PC`, word at `RESET_PC`).
